// File: rtl/bus_slot_sequencer_if.sv
// Bus-slot sequencer signal bundle: CPU slot controls in, slot timing strobes out.
// Latency: n/a (wires only).
// Backpressure: none; the slave side is a free-running timing generator.
interface bus_slot_sequencer_if;
  logic [1:0] cpu_div_i;
  logic       cpu_halt_i;
  logic       cpu_we_i;
  logic       ram_en_i;
  logic       io_en_i;
  logic       io_stretch_i;
  logic       cpu_be_o;
  logic       cpu_clock_o;
  logic       bus_valid_o;
  logic       io_valid_o;
  logic       cpu_ram_oe_o;
  logic       cpu_ram_we_o;
  logic       cpu_io_oe_o;
  logic       wb_addr_oe_o;
  logic       wb_ready_o;
  logic       period_start_o;

  modport slave (
    input  cpu_div_i, cpu_halt_i, cpu_we_i, ram_en_i, io_en_i, io_stretch_i,
    output cpu_be_o, cpu_clock_o, bus_valid_o, io_valid_o, cpu_ram_oe_o,
           cpu_ram_we_o, cpu_io_oe_o, wb_addr_oe_o, wb_ready_o, period_start_o
  );

  modport master (
    output cpu_div_i, cpu_halt_i, cpu_we_i, ram_en_i, io_en_i, io_stretch_i,
    input  cpu_be_o, cpu_clock_o, bus_valid_o, io_valid_o, cpu_ram_oe_o,
           cpu_ram_we_o, cpu_io_oe_o, wb_addr_oe_o, wb_ready_o, period_start_o
  );
endinterface

// File: rtl/bus_slot_sequencer.sv
// CPU/Wishbone bus-slot timing generator: free-running period counter, optional CPU slot per period.
// Latency: all outputs registered; a phase at count P is visible while the counter shows P.
// Backpressure: none; optional Phi2 stretch (macro BUS_SLOT_STRETCH_EN) holds the counter instead.
module bus_slot_sequencer #(
  parameter int CNT_WIDTH   = 6,
  parameter int WB_DRAIN    = 6,
  parameter int BE_TO_VALID = 3,
  parameter int VALID_TO_IO = 2,
  parameter int IO_TO_PHI   = 2,
  parameter int PHI_HIGH    = 5,
  parameter int HOLD        = 2,
  parameter int RELEASE     = 3,
  parameter int MAX_STRETCH = 7
) (
  input logic                wb_clock_i,
  input logic                wb_reset_n_i,
  bus_slot_sequencer_if.slave bus
);

  // Absolute phase positions within the period.
  localparam int BE_S  = WB_DRAIN;
  localparam int VAL_S = BE_S + BE_TO_VALID;
  localparam int IO_S  = VAL_S + VALID_TO_IO;
  localparam int PHI_S = IO_S + IO_TO_PHI;
  localparam int PHI_E = PHI_S + PHI_HIGH;
  localparam int BE_E  = PHI_E + HOLD;
  localparam int WB_S  = BE_E + RELEASE;
  localparam int RDY_S = WB_S + 1;
  localparam int CNT_MAX = (2 ** CNT_WIDTH) - 1;

  if (RDY_S >= CNT_MAX || WB_DRAIN < 1 || BE_TO_VALID < 1 || VALID_TO_IO < 1 ||
      IO_TO_PHI < 1 || PHI_HIGH < 1 || HOLD < 1 || RELEASE < 1 || MAX_STRETCH < 0) begin : g_bad_cfg
    $fatal(1, "bus_slot_sequencer: slot phases do not fit in the period or an offset is < 1");
  end

  // Outputs are registered, so each phase acts on the edge that moves the counter onto it.
  localparam logic [CNT_WIDTH-1:0] E_BE   = CNT_WIDTH'(BE_S - 1);
  localparam logic [CNT_WIDTH-1:0] E_VAL  = CNT_WIDTH'(VAL_S - 1);
  localparam logic [CNT_WIDTH-1:0] E_IO   = CNT_WIDTH'(IO_S - 1);
  localparam logic [CNT_WIDTH-1:0] E_PHS  = CNT_WIDTH'(PHI_S - 1);
  localparam logic [CNT_WIDTH-1:0] E_PHE  = CNT_WIDTH'(PHI_E - 1);
  localparam logic [CNT_WIDTH-1:0] E_BEE  = CNT_WIDTH'(BE_E - 1);
  localparam logic [CNT_WIDTH-1:0] E_WBS  = CNT_WIDTH'(WB_S - 1);
  localparam logic [CNT_WIDTH-1:0] E_RDY  = CNT_WIDTH'(RDY_S - 1);
  localparam logic [CNT_WIDTH-1:0] E_WRAP = '1;

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [2:0]           period_idx_q;
  logic                 slot_act_q;
  logic                 primed_q;
  logic [2:0]           div_mask;
  logic                 at_wrap;
  logic                 decide;
  logic                 slot_next;
  logic                 slot_eff;
  logic                 hold;

  logic be_q, phi_q, valid_q, io_valid_q, ram_oe_q, ram_we_q, io_oe_q;
  logic addr_oe_q, ready_q, pstart_q;

  // The period right after reset starts at count 0 without a wrap edge, so its
  // slot decision is taken on the first edge out of count 0 instead.
  assign div_mask  = 3'((4'd1 << bus.cpu_div_i) - 4'd1);
  assign at_wrap   = (cnt_q == E_WRAP);
  assign decide    = at_wrap || (!primed_q && cnt_q == '0);
  assign slot_next = !bus.cpu_halt_i && ((period_idx_q & div_mask) == 3'd0);
  assign slot_eff  = decide ? slot_next : slot_act_q;

`ifdef BUS_SLOT_STRETCH_EN
  localparam int SW = (MAX_STRETCH > 0) ? $clog2(MAX_STRETCH + 1) : 1;
  logic [SW-1:0] stretch_cnt_q;

  assign hold = slot_act_q && (cnt_q == E_PHE) && bus.io_stretch_i &&
                (stretch_cnt_q < SW'(MAX_STRETCH));

  // Count held Phi2 cycles in this slot; cleared once BE is released.
  always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      stretch_cnt_q <= '0;
    end else if (hold) begin
      stretch_cnt_q <= stretch_cnt_q + SW'(1);
    end else if (slot_act_q && cnt_q == E_BEE) begin
      stretch_cnt_q <= '0;
    end
  end
`else
  logic unused_stretch;
  assign hold           = 1'b0;
  assign unused_stretch = bus.io_stretch_i;
`endif

  // Period counter; wraps naturally and freezes while Phi2 is being stretched.
  always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      cnt_q <= '0;
    end else if (!hold) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  // Per-period slot decision: div/halt only take effect at a period boundary.
  always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      slot_act_q   <= 1'b0;
      period_idx_q <= 3'd0;
      primed_q     <= 1'b0;
    end else if (decide) begin
      slot_act_q   <= slot_next;
      period_idx_q <= period_idx_q + 3'd1;
      primed_q     <= 1'b1;
    end
  end

  // Slot phase strobes; Wishbone keeps its grant through skipped periods.
  always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      be_q       <= 1'b0;
      phi_q      <= 1'b0;
      valid_q    <= 1'b0;
      io_valid_q <= 1'b0;
      ram_oe_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      io_oe_q    <= 1'b0;
      addr_oe_q  <= 1'b0;
      ready_q    <= 1'b0;
      pstart_q   <= 1'b0;
    end else begin
      pstart_q <= at_wrap;
      if (at_wrap && slot_next) begin
        ready_q <= 1'b0;
      end
      if (slot_eff) begin
        if (cnt_q == E_BE) begin
          be_q      <= 1'b1;
          addr_oe_q <= 1'b0;
        end
        if (cnt_q == E_VAL) begin
          valid_q  <= 1'b1;
          ram_oe_q <= bus.ram_en_i & ~bus.cpu_we_i;
          io_oe_q  <= bus.io_en_i;
        end
        if (cnt_q == E_IO) begin
          io_valid_q <= 1'b1;
        end
        if (cnt_q == E_PHS) begin
          phi_q    <= 1'b1;
          // A late flip of cpu_we_i must never open both RAM strobes at once.
          ram_we_q <= bus.ram_en_i & bus.cpu_we_i & ~ram_oe_q;
        end
        if (cnt_q == E_PHE && !hold) begin
          phi_q    <= 1'b0;
          ram_we_q <= 1'b0;
        end
        if (cnt_q == E_BEE) begin
          be_q       <= 1'b0;
          valid_q    <= 1'b0;
          io_valid_q <= 1'b0;
          ram_oe_q   <= 1'b0;
          io_oe_q    <= 1'b0;
        end
        if (cnt_q == E_WBS) begin
          addr_oe_q <= 1'b1;
        end
        if (cnt_q == E_RDY) begin
          ready_q <= 1'b1;
        end
      end
    end
  end

  assign bus.cpu_be_o       = be_q;
  assign bus.cpu_clock_o    = phi_q;
  assign bus.bus_valid_o    = valid_q;
  assign bus.io_valid_o     = io_valid_q;
  assign bus.cpu_ram_oe_o   = ram_oe_q;
  assign bus.cpu_ram_we_o   = ram_we_q;
  assign bus.cpu_io_oe_o    = io_oe_q;
  assign bus.wb_addr_oe_o   = addr_oe_q;
  assign bus.wb_ready_o     = ready_q;
  assign bus.period_start_o = pstart_q;

endmodule
